// File: rtl/tlb_op_seq_pkg.sv
// Shared types and constants for the commit-stage TLB instruction sequencer.
package tlb_op_seq_pkg;

  localparam int TLB_ENTRIES = 32;
  localparam int TLB_INDEX   = 5;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'd0,
    OP_TLBR  = 2'd1,
    OP_TLBWI = 2'd2,
    OP_TLBWR = 2'd3
  } tlb_seq_op_t;

  typedef enum logic [1:0] {
    TU_PROBE = 2'd0,
    TU_READ  = 2'd1,
    TU_WRITE = 2'd2
  } tu_req_op_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_DONE  = 2'd2
  } tlb_seq_state_t;

  // Both write flavours look identical to the TLB unit; only the index source differs.
  function automatic tu_req_op_t seq_to_tu_op(input tlb_seq_op_t op);
    case (op)
      OP_TLBP: return TU_PROBE;
      OP_TLBR: return TU_READ;
      default: return TU_WRITE;
    endcase
  endfunction

endpackage

// File: rtl/tlb_op_seq_cp0_random_ctr.sv
// CP0 Random register: free-running down counter that wraps at Wired.
module cp0_random_ctr #(
  parameter int TLB_ENTRIES = tlb_op_seq_pkg::TLB_ENTRIES,
  parameter int TLB_INDEX   = tlb_op_seq_pkg::TLB_INDEX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wired_wen,
  input  logic [TLB_INDEX-1:0] cp0_wired,
  output logic [TLB_INDEX-1:0] random
);
  import tlb_op_seq_pkg::*;

  localparam logic [TLB_INDEX-1:0] LP_RANDOM_MAX = TLB_INDEX'(TLB_ENTRIES - 1);

  logic [TLB_INDEX-1:0] r_random;

  // Reaching Wired (or any Wired write) reloads the top entry, so Random never
  // lands on a wired entry; a Wired at or above the top pins the counter there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_random <= LP_RANDOM_MAX;
    end else if (wired_wen || (r_random <= cp0_wired)) begin
      r_random <= LP_RANDOM_MAX;
    end else begin
      r_random <= r_random - TLB_INDEX'(1);
    end
  end

  assign random = r_random;

endmodule

// File: rtl/tlb_op_seq.sv
// Commit-stage sequencer for TLBP/TLBR/TLBWI/TLBWR: stalls, issues one TLB
// request, then pulses the CP0 strobes, retire and refetch flush.
module tlb_op_seq #(
  parameter int TLB_ENTRIES = tlb_op_seq_pkg::TLB_ENTRIES,
  parameter int TLB_INDEX   = tlb_op_seq_pkg::TLB_INDEX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [1:0]           req_op,
  input  logic                 exception_valid,
  output logic                 req_done,
  output logic                 stall,
  output logic                 flush,
  input  logic [TLB_INDEX-1:0] cp0_index,
  input  logic [TLB_INDEX-1:0] cp0_wired,
  input  logic                 wired_wen,
  output logic                 tlb_req_valid,
  output logic [1:0]           tlb_req_op,
  output logic [TLB_INDEX-1:0] tlb_req_index,
  input  logic                 tlb_resp_valid,
  input  logic                 tlb_resp_hit,
  input  logic [TLB_INDEX-1:0] tlb_resp_index,
  output logic                 is_tlbp,
  output logic                 is_tlbr,
  output logic [31:0]          probe_index,
  output logic [TLB_INDEX-1:0] random
);
  import tlb_op_seq_pkg::*;

  localparam logic [1:0] S_IDLE  = SEQ_IDLE;
  localparam logic [1:0] S_ISSUE = SEQ_ISSUE;
  localparam logic [1:0] S_DONE  = SEQ_DONE;

  localparam logic [31:0] LP_PROBE_MISS = 32'h8000_0000;

  logic [1:0]           r_state;
  tlb_seq_op_t          r_op;
  logic [1:0]           r_req_op;
  logic [TLB_INDEX-1:0] r_req_index;
  logic [31:0]          r_probe_index;

  logic                 w_accept;
  logic [TLB_INDEX-1:0] w_random;
  tlb_seq_op_t          w_req_op;

  cp0_random_ctr #(
    .TLB_ENTRIES (TLB_ENTRIES),
    .TLB_INDEX   (TLB_INDEX)
  ) u_random (
    .clk       (clk),
    .reset     (reset),
    .wired_wen (wired_wen),
    .cp0_wired (cp0_wired),
    .random    (w_random)
  );

  assign w_req_op = tlb_seq_op_t'(req_op);
  assign w_accept = (r_state == S_IDLE) && req_valid && !exception_valid;

  // TLBWR snapshots Random at accept; the counter keeps running afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_op          <= OP_TLBP;
      r_req_op      <= 2'd0;
      r_req_index   <= '0;
      r_probe_index <= LP_PROBE_MISS;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_ISSUE;
            r_op     <= w_req_op;
            r_req_op <= seq_to_tu_op(w_req_op);
            case (w_req_op)
              OP_TLBR, OP_TLBWI: r_req_index <= cp0_index;
              OP_TLBWR:          r_req_index <= w_random;
              default:           r_req_index <= '0;
            endcase
          end
        end
        S_ISSUE: begin
          if (tlb_resp_valid) begin
            r_state <= S_DONE;
            if (r_op == OP_TLBP) begin
              r_probe_index <= {~tlb_resp_hit, {(31 - TLB_INDEX){1'b0}},
                                (tlb_resp_hit ? tlb_resp_index : {TLB_INDEX{1'b0}})};
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall         = w_accept || (r_state == S_ISSUE) || (r_state == S_DONE);
  assign tlb_req_valid = (r_state == S_ISSUE);
  assign tlb_req_op    = r_req_op;
  assign tlb_req_index = r_req_index;
  assign req_done      = (r_state == S_DONE);
  assign flush         = (r_state == S_DONE);
  assign is_tlbp       = (r_state == S_DONE) && (r_op == OP_TLBP);
  assign is_tlbr       = (r_state == S_DONE) && (r_op == OP_TLBR);
  assign probe_index   = r_probe_index;
  assign random        = w_random;

endmodule

// File: doc/tlb_op_seq.md
Name: tlb_op_seq

Overview:
- Commit-stage sequencer for TLBP/TLBR/TLBWI/TLBWR in the dual-issue in-order core.
- Accepts one TLB instruction from commit, stalls the pipeline, issues one request to the TLB unit and waits for its response.
- Then pulses the CP0 update strobes (is_tlbp/is_tlbr) and a refetch flush.
- Also owns the CP0 Random counter used by TLBWR.

Parameters:
TLB_ENTRIES, 32, number of TLB entries (power of two)
TLB_INDEX, 5, log2(TLB_ENTRIES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  committing TLB instruction present; held until req_done
req_op  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR
exception_valid  in  1  commit-stage exception this cycle
req_done  out  1  one-cycle pulse: instruction retired
stall  out  1  freeze fetch..commit while sequencing
flush  out  1  one-cycle refetch pulse after any TLB op
cp0_index  in  TLB_INDEX  CP0 Index.index field
cp0_wired  in  TLB_INDEX  CP0 Wired.wired field
wired_wen  in  1  mtc0 to Wired committing this cycle
tlb_req_valid  out  1  request to TLB unit
tlb_req_op  out  2  0=probe, 1=read, 2=write
tlb_req_index  out  TLB_INDEX  entry for read/write
tlb_resp_valid  in  1  TLB unit response (may coincide with tlb_req_valid)
tlb_resp_hit  in  1  probe hit
tlb_resp_index  in  TLB_INDEX  probe hit index
is_tlbp  out  1  one-cycle strobe: CP0 latches probe_index into Index
is_tlbr  out  1  one-cycle strobe: CP0 latches TLB read data
probe_index  out  32  {~hit, 26'b0, index}; bit31 = P
random  out  TLB_INDEX  CP0 Random value

Behaviour:
- Reset (reset==0 at posedge) state and outputs:
  - state=IDLE; random=TLB_ENTRIES-1.
  - All strobes/valids 0; tlb_req_op=0, tlb_req_index=0; probe_index=32'h8000_0000.
  - Reset mid-operation abandons the op; no strobe is emitted.
- FSM states:
  - IDLE:
    - stall = req_valid & ~exception_valid (combinational).
    - Transition to ISSUE when req_valid & ~exception_valid: latch op; latch index = cp0_index for TLBR/TLBWI, = random for TLBWR.
    - exception_valid has priority: the request is not accepted and the state stays IDLE.
  - ISSUE:
    - tlb_req_valid=1; stall=1; tlb_req_op/tlb_req_index from latched values; outputs held stable until tlb_resp_valid.
    - On tlb_resp_valid: latch hit/index (probe only) and go to DONE.
    - No timeout.
  - DONE:
    - stall=1; req_done=1; flush=1.
    - is_tlbp=1 if op was TLBP; is_tlbr=1 if op was TLBR; TLBWI/TLBWR emit neither.
    - Next state IDLE unconditionally.
- Latency (accept in cycle 0, TLB responds in the same cycle as the request): tlb_req_valid cycle 1, strobes/req_done/flush cycle 2, IDLE cycle 3. Each extra TLB wait cycle adds one.
- stall is never deasserted between accept and DONE inclusive. In IDLE, req_valid is ignored during the cycle following DONE only if req_valid has already dropped; commit drops req_valid on req_done.
- probe_index registered, updated only on probe response; hit=0 gives 32'h8000_0000.
- Random counter:
  - Each cycle: if wired_wen, random <= TLB_ENTRIES-1.
  - Else if random <= cp0_wired, random <= TLB_ENTRIES-1.
  - Else random <= random-1.
  - cp0_wired >= TLB_ENTRIES-1 keeps random at TLB_ENTRIES-1.
  - Counter keeps running while busy; TLBWR uses the value captured at accept.
- Width rules: all index arithmetic is unsigned TLB_INDEX bits; probe_index bits 30:TLB_INDEX are zero.

Decomposition:
- Shared package mips.svh / tu.svh holds:
  - tlb_seq_op_t enum (TLBP, TLBR, TLBWI, TLBWR).
  - tu_req_op_t enum (PROBE, READ, WRITE).
  - TLB_ENTRIES / TLB_INDEX constants.
  - tlb_seq_state_t enum (IDLE, ISSUE, DONE).
- One sub-module, cp0_random_ctr, holds the Random counter (clk, reset, wired_wen, cp0_wired, random).

Test Plan:
- Reset, then idle 5 cycles with cp0_wired=0 -> random 31,30,29,28,27; all strobes 0; probe_index=32'h8000_0000.
- TLBP with TLB responding in the same cycle, hit=1, index=7:
  - tlb_req_op=0 in cycle 1.
  - Cycle 2: is_tlbp=1, probe_index=32'h0000_0007, req_done=1, flush=1.
  - stall high cycles 0-2.
- TLBR with cp0_index=12 and TLB responding 3 cycles late -> tlb_req_index=12 held for 4 cycles, then one is_tlbr pulse; is_tlbp stays 0.
- TLBWR accepted when random=20 -> tlb_req_op=2, tlb_req_index=20 even though random keeps decrementing; neither is_tlbp nor is_tlbr fires.
- cp0_wired=28, count down -> sequence 31,30,29,28,31. Then a wired_wen pulse when random=29 -> 31 next cycle.
- Edge cases:
  - req_valid and exception_valid together -> no accept, stall=0, tlb_req_valid stays 0.
  - reset asserted in ISSUE -> IDLE next cycle, no strobes.
